// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - forwarding select and load-use hazard unit with in-flight writer tracker
module forward_scoreboard #(
  parameter  int REG_W    = 4,
  parameter  int STAGES   = 3,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic [REG_W-1:0] id_dst,
  output logic [SEL_W-1:0] sel_src1,
  output logic [SEL_W-1:0] sel_src2,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_count
);

  // Tracker: entry 0 is the writer one stage ahead of the consumer.
  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            ld_q, ld_d;
  logic [STAGES-1:0][REG_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

  // Youngest-writer search results per source.
  logic             hit1, hit2;
  logic             ldh1, ldh2;
  logic [SEL_W-1:0] bsel1, bsel2;
  logic             match1, match2;
  logic             stall_raw;
  logic             blocked;

  // Scan from oldest to youngest so the lowest matching entry wins.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    ldh1  = 1'b0;
    ldh2  = 1'b0;
    bsel1 = '0;
    bsel2 = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (v_q[k] && (dst_q[k] == id_src1)) begin
        hit1  = 1'b1;
        ldh1  = ld_q[k] && (k < LOAD_LAT);
        bsel1 = SEL_W'(k + 1);
      end
      if (v_q[k] && (dst_q[k] == id_src2)) begin
        hit2  = 1'b1;
        ldh2  = ld_q[k] && (k < LOAD_LAT);
        bsel2 = SEL_W'(k + 1);
      end
    end
  end

  // Resolve selects and stall; a frozen or squashed consumer asserts nothing.
  always_comb begin
    match1       = id_valid && id_src1_used && hit1;
    match2       = id_valid && id_src2_used && hit2;
    blocked      = freeze || flush;
    stall_raw    = 1'b0;
    sel_src1     = '0;
    sel_src2     = '0;
    if (fwd_en) begin
      // A load result that is too close cannot be bypassed yet.
      stall_raw = (match1 && ldh1) || (match2 && ldh2);
      if (!blocked && match1 && !ldh1) sel_src1 = bsel1;
      if (!blocked && match2 && !ldh2) sel_src2 = bsel2;
    end else begin
      // Without bypass paths, any pending writer must retire first.
      stall_raw = match1 || match2;
    end
    hazard_stall = stall_raw && !blocked;
  end

  // Next tracker contents: hold on freeze, otherwise shift in the consumer or a bubble.
  always_comb begin
    v_d   = v_q;
    ld_d  = ld_q;
    dst_d = dst_q;
    if (!freeze) begin
      if (flush || hazard_stall || !id_valid) begin
        v_d   = {v_q[STAGES-2:0], 1'b0};
        ld_d  = {ld_q[STAGES-2:0], 1'b0};
        dst_d = {dst_q[STAGES-2:0], {REG_W{1'b0}}};
      end else begin
        v_d   = {v_q[STAGES-2:0], id_wb_en};
        ld_d  = {ld_q[STAGES-2:0], id_mem_read};
        dst_d = {dst_q[STAGES-2:0], id_dst};
      end
    end
  end

  // Saturating count of cycles spent stalling.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!freeze && hazard_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      ld_q        <= '0;
      dst_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      ld_q        <= ld_d;
      dst_q       <= dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - self-checking bench for forward_scoreboard
module tb_forward_scoreboard;

  localparam int REG_W    = 4;
  localparam int STAGES   = 3;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 4;
  localparam int SEL_W    = $clog2(STAGES + 1);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, freeze, flush, fwd_en;
  logic             id_valid, id_src1_used, id_src2_used, id_wb_en, id_mem_read;
  logic [REG_W-1:0] id_src1, id_src2, id_dst;
  logic [SEL_W-1:0] sel_src1, sel_src2;
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_count;

  forward_scoreboard #(
    .REG_W(REG_W), .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
    .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_dst(id_dst),
    .sel_src1(sel_src1), .sel_src2(sel_src2),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: list of recently issued instructions, most recent first.
  typedef struct { bit v; int dst; bit ld; } wr_t;
  wr_t hist[$];
  int  m_cnt;
  int  m_sel1, m_sel2;
  bit  m_stall;

  function automatic int youngest(input int src, input bit used);
    if (!(id_valid && used)) return -1;
    foreach (hist[k]) if (hist[k].v && hist[k].dst == src) return k;
    return -1;
  endfunction

  task automatic model_eval();
    int  k1, k2;
    bit  late1, late2;
    k1 = youngest(int'(id_src1), id_src1_used);
    k2 = youngest(int'(id_src2), id_src2_used);
    late1 = (k1 >= 0) && hist[k1].ld && (k1 < LOAD_LAT);
    late2 = (k2 >= 0) && hist[k2].ld && (k2 < LOAD_LAT);
    m_sel1 = 0; m_sel2 = 0; m_stall = 0;
    if (freeze || flush) return;
    if (fwd_en) begin
      m_stall = late1 || late2;
      if (k1 >= 0 && !late1) m_sel1 = k1 + 1;
      if (k2 >= 0 && !late2) m_sel2 = k2 + 1;
    end else begin
      m_stall = (k1 >= 0) || (k2 >= 0);
    end
  endtask

  task automatic model_clock();
    wr_t e;
    model_eval();
    if (rst) begin
      hist.delete();
      for (int i = 0; i < STAGES; i++) begin e.v = 0; e.dst = 0; e.ld = 0; hist.push_back(e); end
      m_cnt = 0;
    end else if (!freeze) begin
      e.v = 0; e.dst = 0; e.ld = 0;
      if (!(flush || m_stall || !id_valid)) begin
        e.v = id_wb_en; e.dst = int'(id_dst); e.ld = id_mem_read;
      end
      hist.push_front(e);
      void'(hist.pop_back());
      if (m_stall && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic look(input string tag);
    @(negedge clk);
    model_eval();
    check({tag, "_sel1"},  32'(sel_src1),     32'(m_sel1));
    check({tag, "_sel2"},  32'(sel_src2),     32'(m_sel2));
    check({tag, "_stall"}, 32'(hazard_stall), 32'(m_stall));
    check({tag, "_cnt"},   32'(stall_count),  32'(m_cnt));
  endtask

  task automatic adv();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                       input bit wb, input int d, input bit ld);
    id_valid = v; id_src1 = REG_W'(s1); id_src1_used = u1; id_src2 = REG_W'(s2);
    id_src2_used = u2; id_wb_en = wb; id_dst = REG_W'(d); id_mem_read = ld;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin look("idle"); adv(); end
  endtask

  task automatic do_reset();
    rst = 1; drive(0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    rst = 0;
  endtask

  initial begin
    wr_t e;
    e.v = 0; e.dst = 0; e.ld = 0;
    for (int i = 0; i < STAGES; i++) hist.push_back(e);
    m_cnt = 0;
    rst = 1; freeze = 0; flush = 0; fwd_en = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    look("reset");
    check("reset_stall", 32'(hazard_stall), 0);
    check("reset_cnt",   32'(stall_count),  0);
    adv();
    rst = 0;

    // ADD r1 then SUB r2,r1,r3
    drive(1, 0, 0, 0, 0, 1, 1, 0); look("t1a"); adv();
    drive(1, 1, 1, 3, 1, 1, 2, 0); look("t1b");
    check("t1_sel1", 32'(sel_src1), 1);
    check("t1_sel2", 32'(sel_src2), 0);
    check("t1_stall", 32'(hazard_stall), 0);
    adv(); idle(3);

    // LDR r4 then ADD r5,r4,r4
    do_reset();
    drive(1, 13, 1, 0, 0, 1, 4, 1); look("t2a"); adv();
    drive(1, 4, 1, 4, 1, 1, 5, 0); look("t2b");
    check("t2_stall", 32'(hazard_stall), 1);
    adv(); look("t2c");
    check("t2_sel1", 32'(sel_src1), 2);
    check("t2_sel2", 32'(sel_src2), 2);
    check("t2_stall_off", 32'(hazard_stall), 0);
    check("t2_cnt", 32'(stall_count), 1);
    adv(); idle(3);

    // Two writers to r1: youngest wins
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0); look("t3a"); adv();
    drive(1, 0, 0, 0, 0, 1, 1, 0); look("t3b"); adv();
    drive(1, 1, 1, 1, 0, 0, 0, 0); look("t3c");
    check("t3_sel1", 32'(sel_src1), 1);
    adv(); idle(3);

    // Stall-only mode
    do_reset();
    fwd_en = 0;
    drive(1, 0, 0, 0, 0, 1, 1, 0); look("t4a"); adv();
    drive(1, 1, 1, 0, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      look("t4s"); check("t4_stall", 32'(hazard_stall), 1); adv();
    end
    look("t4e");
    check("t4_stall_off", 32'(hazard_stall), 0);
    check("t4_sel1", 32'(sel_src1), 0);
    check("t4_cnt", 32'(stall_count), 3);
    adv();
    fwd_en = 1; idle(3);

    // Freeze during a load-use hazard
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 4, 1); look("t5a"); adv();
    drive(1, 4, 1, 0, 0, 1, 5, 0);
    freeze = 1;
    for (int i = 0; i < 4; i++) begin
      look("t5f");
      check("t5_frz_stall", 32'(hazard_stall), 0);
      check("t5_frz_cnt", 32'(stall_count), 0);
      adv();
    end
    freeze = 0;
    look("t5u"); check("t5_stall", 32'(hazard_stall), 1); adv();
    look("t5v"); check("t5_sel1", 32'(sel_src1), 2); check("t5_cnt", 32'(stall_count), 1);
    adv(); idle(3);

    // Reset during a stall
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 4, 1); look("t6a"); adv();
    drive(1, 4, 1, 4, 1, 1, 5, 0); look("t6b");
    check("t6_stall", 32'(hazard_stall), 1);
    rst = 1; adv(); rst = 0;
    look("t6c");
    check("t6_stall_off", 32'(hazard_stall), 0);
    check("t6_sel1", 32'(sel_src1), 0);
    check("t6_cnt", 32'(stall_count), 0);
    adv(); idle(3);

    // Flush beats a load-use hazard
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 4, 1); look("t7a"); adv();
    drive(1, 4, 1, 0, 0, 1, 5, 0); flush = 1; look("t7b");
    check("t7_stall", 32'(hazard_stall), 0);
    adv(); flush = 0;
    look("t7c"); check("t7_cnt", 32'(stall_count), 0);
    adv(); idle(3);

    // Randomized traffic over a small register space to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 99) < 2);
      freeze = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      fwd_en = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 2) == 0);
      look("rnd");
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
